// File: rtl/alu_slice_seq.sv
// Multi-cycle ALU: ADD/SUB/AND/OR on WIDTH-bit operands, SLICE bits per clock, LSB slice first.
// Result and flags are registered and only change with the one-cycle done pulse.
module alu_slice_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       opcode,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             overflow
);

    localparam int unsigned N  = WIDTH / SLICE;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;
    typedef enum logic [1:0] {OpAdd, OpSub, OpAnd, OpOr} op_e;

    state_e           state_q;
    op_e              op_q;
    logic [WIDTH-1:0] a_q, b_q, shadow_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    logic [SLICE-1:0] a_k, b_k, slice_res;
    logic [SLICE:0]   ext;
    logic             carry_nx;
    logic [WIDTH-1:0] shadow_nx;
    logic             b_msb_eff, ovf_nx;
    int               idx;

    always_comb begin
        idx       = int'(cnt_q);
        a_k       = a_q[idx*SLICE +: SLICE];
        b_k       = b_q[idx*SLICE +: SLICE];
        ext       = '0;
        slice_res = '0;
        carry_nx  = 1'b0;
        unique case (op_q)
            OpAdd: begin
                ext       = {1'b0, a_k} + {1'b0, b_k} + {{SLICE{1'b0}}, carry_q};
                slice_res = ext[SLICE-1:0];
                carry_nx  = ext[SLICE];
            end
            OpSub: begin
                // Top bit of the extended difference is the borrow out of this slice.
                ext       = {1'b0, a_k} - {1'b0, b_k} - {{SLICE{1'b0}}, carry_q};
                slice_res = ext[SLICE-1:0];
                carry_nx  = ext[SLICE];
            end
            OpAnd: slice_res = a_k & b_k;
            OpOr:  slice_res = a_k | b_k;
            default: slice_res = '0;
        endcase
        shadow_nx                     = shadow_q;
        shadow_nx[idx*SLICE +: SLICE] = slice_res;
        b_msb_eff = (op_q == OpSub) ? ~b_q[WIDTH-1] : b_q[WIDTH-1];
        ovf_nx    = ((op_q == OpAdd) || (op_q == OpSub)) &&
                    (a_q[WIDTH-1] == b_msb_eff) && (shadow_nx[WIDTH-1] != a_q[WIDTH-1]);
    end

    assign busy = (state_q == StRun);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= OpAdd;
            a_q      <= '0;
            b_q      <= '0;
            shadow_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            done     <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            zero     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        op_q     <= op_e'(opcode);
                        carry_q  <= (opcode[1] == 1'b0) ? cin : 1'b0;
                        cnt_q    <= '0;
                        shadow_q <= '0;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    shadow_q <= shadow_nx;
                    carry_q  <= carry_nx;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        result   <= shadow_nx;
                        cout     <= carry_nx;
                        zero     <= (shadow_nx == '0);
                        overflow <= ovf_nx;
                        done     <= 1'b1;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_slice_seq.sv
// Scoreboard bench for alu_slice_seq: an 8/4 instance and a 4/1 instance on a shared clock.
module tb_alu_slice_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 8-bit, 4-bit slice instance
    logic       start, cin, busy, done, cout, zero, overflow;
    logic [7:0] a, b, result;
    logic [1:0] opcode;
    // 4-bit, 1-bit slice instance
    logic       s_start, s_cin, s_busy, s_done, s_cout, s_zero, s_overflow;
    logic [3:0] s_a, s_b, s_result;
    logic [1:0] s_opcode;

    int checks = 0;
    int errors = 0;
    logic [10:0] q1[$];
    logic [6:0]  q2[$];

    alu_slice_seq #(.WIDTH(8), .SLICE(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .opcode(opcode), .cin(cin),
        .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero),
        .overflow(overflow)
    );

    alu_slice_seq #(.WIDTH(4), .SLICE(1)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .a(s_a), .b(s_b), .opcode(s_opcode),
        .cin(s_cin), .busy(s_busy), .done(s_done), .result(s_result), .cout(s_cout),
        .zero(s_zero), .overflow(s_overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: pop and compare {result, cout, zero, overflow} on every done.
    logic [10:0] e1;
    logic [6:0]  e2;
    always @(negedge clk) begin
        if (!rst && done) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL w8 unexpected done: result 0x%0h", result);
            end else begin
                e1 = q1.pop_front();
                if ({result, cout, zero, overflow} !== e1) begin
                    errors++;
                    $display("FAIL w8 result/flags: got 0x%0h c%0b z%0b v%0b, expected 0x%0h c%0b z%0b v%0b",
                             result, cout, zero, overflow, e1[10:3], e1[2], e1[1], e1[0]);
                end
            end
        end
        if (!rst && s_done) begin
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL w4 unexpected done: result 0x%0h", s_result);
            end else begin
                e2 = q2.pop_front();
                if ({s_result, s_cout, s_zero, s_overflow} !== e2) begin
                    errors++;
                    $display("FAIL w4 result/flags: got 0x%0h c%0b z%0b v%0b, expected 0x%0h c%0b z%0b v%0b",
                             s_result, s_cout, s_zero, s_overflow, e2[6:3], e2[2], e2[1], e2[0]);
                end
            end
        end
    end

    // Waits (bounded) for done on the 8-bit instance; called #1 after the start edge.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic op8(input logic [1:0] op, input logic [7:0] av, input logic [7:0] bv,
                       input logic ci, input logic [7:0] er, input logic ec, input logic ez,
                       input logic eo);
        int lat, bcnt;
        @(negedge clk);
        a = av; b = bv; opcode = op; cin = ci; start = 1'b1;
        q1.push_back({er, ec, ez, eo});
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, bcnt);
        chk("w8 latency", lat, 2);
        chk("w8 busy cycles", bcnt, 2);
        chk("w8 busy low at done", {31'd0, busy}, 0);
    endtask

    task automatic op4(input logic [1:0] op, input logic [3:0] av, input logic [3:0] bv,
                       input logic ci, input logic [3:0] er, input logic ec, input logic ez,
                       input logic eo);
        int lat, bcnt;
        @(negedge clk);
        s_a = av; s_b = bv; s_opcode = op; s_cin = ci; s_start = 1'b1;
        q2.push_back({er, ec, ez, eo});
        @(posedge clk); #1;
        s_start = 1'b0;
        lat  = 0;
        bcnt = 0;
        while (!s_done && lat < 20) begin
            if (s_busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        chk("w4 latency", lat, 4);
        chk("w4 busy cycles", bcnt, 4);
    endtask

    initial begin
        int lat, bcnt;
        start = 0; cin = 0; a = 0; b = 0; opcode = 0;
        s_start = 0; s_cin = 0; s_a = 0; s_b = 0; s_opcode = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs w8", {20'd0, busy, done, result, cout, zero, overflow}, 0);
        chk("reset outputs w4", {24'd0, s_busy, s_done, s_result, s_cout, s_zero, s_overflow}, 0);
        @(negedge clk);
        rst = 1'b0;

        op8(2'b00, 8'h96, 8'h69, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
        op8(2'b00, 8'h97, 8'h69, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        op8(2'b00, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1);
        op8(2'b01, 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
        op8(2'b01, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
        op8(2'b01, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1);
        op8(2'b01, 8'h05, 8'h03, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        op8(2'b10, 8'hAA, 8'h0F, 1'b1, 8'h0A, 1'b0, 1'b0, 1'b0);
        op8(2'b11, 8'hA0, 8'h05, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
        op8(2'b10, 8'h55, 8'hAA, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // start while busy with other operands must be ignored
        @(negedge clk);
        a = 8'h10; b = 8'h20; opcode = 2'b00; cin = 0; start = 1'b1;
        q1.push_back({8'h30, 1'b0, 1'b0, 1'b0});
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        a = 8'hFF; b = 8'h11; opcode = 2'b01; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, bcnt);
        chk("busy-ignore latency", lat, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("busy-ignore idle", {31'd0, busy}, 0);

        // start in the done cycle is accepted back-to-back
        @(negedge clk);
        a = 8'h01; b = 8'h02; opcode = 2'b00; start = 1'b1;
        q1.push_back({8'h03, 1'b0, 1'b0, 1'b0});
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, bcnt);
        chk("b2b first latency", lat, 2);
        a = 8'h0F; b = 8'hF0; opcode = 2'b11; start = 1'b1;
        q1.push_back({8'hFF, 1'b0, 1'b0, 1'b0});
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b accepted busy", {31'd0, busy}, 1);
        chk("b2b result hold 1", {24'd0, result}, 32'h03);
        @(posedge clk); #1;
        chk("b2b result hold 2", {24'd0, result}, 32'h03);
        chk("b2b no early done", {31'd0, done}, 0);
        @(posedge clk); #1;
        chk("b2b second done", {31'd0, done}, 1);

        // reset in the first RUN cycle aborts without done
        @(negedge clk);
        a = 8'h12; b = 8'h34; opcode = 2'b00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("abort outputs", {20'd0, busy, done, result, cout, zero, overflow}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        op8(2'b00, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);

        op4(2'b00, 4'b1001, 4'b0110, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0);
        op4(2'b00, 4'b1001, 4'b0111, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        chk("w8 scoreboard drained", q1.size(), 0);
        chk("w4 scoreboard drained", q2.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
